// File: rtl/rv32i_decoder_pkg.sv
// Shared constants for the RV32I decode stage.
// Holds the major-opcode encodings, the one-hot bit positions of the ALU
// operation and instruction-class vectors, the exception vector bit
// positions, the immediate-format selector, and helpers that build one-hot
// vectors and map funct3 onto an ALU operation.
package rv32i_decoder_pkg;

  localparam int unsigned ALU_W = 16;
  localparam int unsigned OPC_W = 11;

  // Major opcodes, inst[6:0]
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Bit positions in o_alu_op
  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_SLL  = 2;
  localparam int unsigned ALU_SLT  = 3;
  localparam int unsigned ALU_SLTU = 4;
  localparam int unsigned ALU_XOR  = 5;
  localparam int unsigned ALU_SRL  = 6;
  localparam int unsigned ALU_SRA  = 7;
  localparam int unsigned ALU_OR   = 8;
  localparam int unsigned ALU_AND  = 9;
  localparam int unsigned ALU_EQ   = 10;
  localparam int unsigned ALU_NE   = 11;
  localparam int unsigned ALU_LT   = 12;
  localparam int unsigned ALU_GE   = 13;
  localparam int unsigned ALU_LTU  = 14;
  localparam int unsigned ALU_GEU  = 15;

  // Bit positions in o_opcode
  localparam int unsigned CLS_RTYPE  = 0;
  localparam int unsigned CLS_ITYPE  = 1;
  localparam int unsigned CLS_LOAD   = 2;
  localparam int unsigned CLS_STORE  = 3;
  localparam int unsigned CLS_BRANCH = 4;
  localparam int unsigned CLS_JAL    = 5;
  localparam int unsigned CLS_JALR   = 6;
  localparam int unsigned CLS_LUI    = 7;
  localparam int unsigned CLS_AUIPC  = 8;
  localparam int unsigned CLS_SYSTEM = 9;
  localparam int unsigned CLS_FENCE  = 10;

  // Bit positions in o_exception = {illegal, ecall, ebreak, mret}
  localparam int unsigned EXC_MRET    = 0;
  localparam int unsigned EXC_EBREAK  = 1;
  localparam int unsigned EXC_ECALL   = 2;
  localparam int unsigned EXC_ILLEGAL = 3;

  typedef enum logic [2:0] {
    ImmNone,
    ImmI,
    ImmS,
    ImmB,
    ImmU,
    ImmJ
  } imm_fmt_e;

  function automatic logic [ALU_W-1:0] alu_bit(input int unsigned idx);
    return ALU_W'(1) << idx;
  endfunction

  function automatic logic [OPC_W-1:0] opc_bit(input int unsigned idx);
    return OPC_W'(1) << idx;
  endfunction

  // Register/immediate arithmetic op from funct3; alt picks SUB or SRA.
  function automatic int unsigned alu_arith(input logic [2:0] funct3, input logic alt);
    int unsigned idx;
    case (funct3)
      3'b000:  idx = alt ? ALU_SUB : ALU_ADD;
      3'b001:  idx = ALU_SLL;
      3'b010:  idx = ALU_SLT;
      3'b011:  idx = ALU_SLTU;
      3'b100:  idx = ALU_XOR;
      3'b101:  idx = alt ? ALU_SRA : ALU_SRL;
      3'b110:  idx = ALU_OR;
      default: idx = ALU_AND;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational immediate generator.
// Ports:
//   i_inst  32-bit instruction word
//   i_fmt   immediate format selector (none/I/S/B/U/J)
//   o_imm   immediate sign-extended from inst[31]; zero for format none
module rv32i_imm_gen
  import rv32i_decoder_pkg::*;
(
  input  logic [31:0] i_inst,
  input  imm_fmt_e    i_fmt,
  output logic [31:0] o_imm
);

  // Opcode bits never contribute to any immediate.
  logic unused_opc;
  assign unused_opc = ^i_inst[6:0];

  always_comb begin
    o_imm = '0;
    case (i_fmt)
      ImmI: o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      ImmS: o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      ImmB: o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      ImmU: o_imm = {i_inst[31:12], 12'b0};
      ImmJ: o_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_decoder.sv
// RV32I decode stage.
// Decodes one instruction per enabled cycle into a registered bundle for
// the execute stage: destination, immediate, funct3, PC, one-hot ALU op,
// one-hot instruction class and exception flags. Register-file read
// addresses are combinational so the register file can be read in parallel.
// Ports:
//   i_clk, i_rst               clock, asynchronous active-high reset
//   i_inst, i_pc, i_ce         instruction, its PC, and its valid strobe
//   i_stall, i_flush           pipeline stall (wins) and stage flush
//   o_rs1_addr, o_rs2_addr     combinational read addresses
//   o_rd_addr, o_imm, o_funct3, o_pc, o_alu_op, o_opcode, o_exception
//                              registered decode results
//   o_ce                       valid strobe to execute
module rv32i_decoder
  import rv32i_decoder_pkg::*;
#(
  parameter int unsigned ILLEGAL_CHECK = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_inst,
  input  logic [31:0]      i_pc,
  input  logic             i_ce,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic [4:0]       o_rs1_addr,
  output logic [4:0]       o_rs2_addr,
  output logic [4:0]       o_rd_addr,
  output logic [31:0]      o_imm,
  output logic [2:0]       o_funct3,
  output logic [31:0]      o_pc,
  output logic [ALU_W-1:0] o_alu_op,
  output logic [OPC_W-1:0] o_opcode,
  output logic [3:0]       o_exception,
  output logic             o_ce
);

  logic [6:0]       opc;
  logic [2:0]       f3;
  logic [6:0]       f7;
  imm_fmt_e         fmt;
  logic [31:0]      imm_d;
  logic [OPC_W-1:0] cls_d;
  logic [ALU_W-1:0] alu_d;
  logic             illegal;
  logic             illegal_eff;
  logic             ecall;
  logic             ebreak;
  logic             mret;
  logic             rs1_zero;
  logic             rs2_used;
  logic             rd_none;

  logic             ce_q;
  logic [4:0]       rd_q;
  logic [31:0]      imm_q;
  logic [2:0]       f3_q;
  logic [31:0]      pc_q;
  logic [ALU_W-1:0] alu_q;
  logic [OPC_W-1:0] opc_q;
  logic [3:0]       exc_q;

  assign opc = i_inst[6:0];
  assign f3  = i_inst[14:12];
  assign f7  = i_inst[31:25];

  always_comb begin
    cls_d    = '0;
    fmt      = ImmNone;
    alu_d    = alu_bit(ALU_ADD);
    illegal  = 1'b0;
    ecall    = 1'b0;
    ebreak   = 1'b0;
    mret     = 1'b0;
    rs1_zero = 1'b0;
    rs2_used = 1'b0;
    rd_none  = 1'b0;

    case (opc)
      OPC_OP: begin
        cls_d    = opc_bit(CLS_RTYPE);
        rs2_used = 1'b1;
        alu_d    = alu_bit(alu_arith(f3, i_inst[30]));
        if (f7 != 7'h00 && f7 != 7'h20) illegal = 1'b1;
        // Alternate encoding exists only for SUB and SRA.
        if (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101) illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        cls_d = opc_bit(CLS_ITYPE);
        fmt   = ImmI;
        // inst[30] is immediate data except for shifts, where it picks SRAI.
        alu_d = alu_bit(alu_arith(f3, (f3 == 3'b101) && i_inst[30]));
        if (f3 == 3'b001 && f7 != 7'h00) illegal = 1'b1;
        if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20) illegal = 1'b1;
      end
      OPC_LOAD: begin
        cls_d = opc_bit(CLS_LOAD);
        fmt   = ImmI;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) illegal = 1'b1;
      end
      OPC_STORE: begin
        cls_d    = opc_bit(CLS_STORE);
        fmt      = ImmS;
        rs2_used = 1'b1;
        rd_none  = 1'b1;
        if (f3 > 3'b010) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        cls_d    = opc_bit(CLS_BRANCH);
        fmt      = ImmB;
        rs2_used = 1'b1;
        rd_none  = 1'b1;
        case (f3)
          3'b000:  alu_d = alu_bit(ALU_EQ);
          3'b001:  alu_d = alu_bit(ALU_NE);
          3'b100:  alu_d = alu_bit(ALU_LT);
          3'b101:  alu_d = alu_bit(ALU_GE);
          3'b110:  alu_d = alu_bit(ALU_LTU);
          3'b111:  alu_d = alu_bit(ALU_GEU);
          default: illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        cls_d    = opc_bit(CLS_JAL);
        fmt      = ImmJ;
        rs1_zero = 1'b1;
      end
      OPC_JALR: begin
        cls_d = opc_bit(CLS_JALR);
        fmt   = ImmI;
        if (f3 != 3'b000) illegal = 1'b1;
      end
      OPC_LUI: begin
        cls_d    = opc_bit(CLS_LUI);
        fmt      = ImmU;
        rs1_zero = 1'b1;
      end
      OPC_AUIPC: begin
        cls_d    = opc_bit(CLS_AUIPC);
        fmt      = ImmU;
        rs1_zero = 1'b1;
      end
      OPC_SYSTEM: begin
        cls_d = opc_bit(CLS_SYSTEM);
        fmt   = ImmI;
        if (f3 == 3'b100) begin
          illegal = 1'b1;
        end else if (f3 == 3'b000) begin
          case (i_inst[31:20])
            12'h000: ecall   = 1'b1;
            12'h001: ebreak  = 1'b1;
            12'h302: mret    = 1'b1;
            default: illegal = 1'b1;
          endcase
        end
      end
      OPC_MISC_MEM: begin
        cls_d = opc_bit(CLS_FENCE);
        fmt   = ImmI;
      end
      default: illegal = 1'b1;
    endcase

    // Compressed or reserved encodings never reach this core.
    if (i_inst[1:0] != 2'b11) illegal = 1'b1;
  end

  assign illegal_eff = (ILLEGAL_CHECK != 0) ? illegal : 1'b0;

  assign o_rs1_addr = rs1_zero ? 5'd0 : i_inst[19:15];
  assign o_rs2_addr = rs2_used ? i_inst[24:20] : 5'd0;

  rv32i_imm_gen u_imm_gen (
    .i_inst (i_inst),
    .i_fmt  (fmt),
    .o_imm  (imm_d)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ce_q  <= 1'b0;
      rd_q  <= '0;
      imm_q <= '0;
      f3_q  <= '0;
      pc_q  <= '0;
      alu_q <= '0;
      opc_q <= '0;
      exc_q <= '0;
    end else if (!i_stall) begin
      // Stall wins over flush: nothing here moves while i_stall is high.
      ce_q <= i_flush ? 1'b0 : i_ce;
      if (i_ce) begin
        rd_q  <= rd_none ? 5'd0 : i_inst[11:7];
        imm_q <= imm_d;
        f3_q  <= f3;
        pc_q  <= i_pc;
        alu_q <= alu_d;
        opc_q <= illegal_eff ? '0 : cls_d;
        exc_q <= {illegal_eff, ecall, ebreak, mret};
      end
    end
  end

  assign o_ce        = ce_q;
  assign o_rd_addr   = rd_q;
  assign o_imm       = imm_q;
  assign o_funct3    = f3_q;
  assign o_pc        = pc_q;
  assign o_alu_op    = alu_q;
  assign o_opcode    = opc_q;
  assign o_exception = exc_q;

endmodule

// File: tb/tb_rv32i_decoder.sv
// Bench for rv32i_decoder: directed scenarios followed by randomized
// instructions and control, compared against a behavioural decoder model.
module tb_rv32i_decoder;
  import rv32i_decoder_pkg::*;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [31:0]      i_inst;
  logic [31:0]      i_pc;
  logic             i_ce;
  logic             i_stall;
  logic             i_flush;
  logic [4:0]       o_rs1_addr;
  logic [4:0]       o_rs2_addr;
  logic [4:0]       o_rd_addr;
  logic [31:0]      o_imm;
  logic [2:0]       o_funct3;
  logic [31:0]      o_pc;
  logic [ALU_W-1:0] o_alu_op;
  logic [OPC_W-1:0] o_opcode;
  logic [3:0]       o_exception;
  logic             o_ce;

  always #5 i_clk = ~i_clk;

  rv32i_decoder #(.ILLEGAL_CHECK(1)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_inst      (i_inst),
    .i_pc        (i_pc),
    .i_ce        (i_ce),
    .i_stall     (i_stall),
    .i_flush     (i_flush),
    .o_rs1_addr  (o_rs1_addr),
    .o_rs2_addr  (o_rs2_addr),
    .o_rd_addr   (o_rd_addr),
    .o_imm       (o_imm),
    .o_funct3    (o_funct3),
    .o_pc        (o_pc),
    .o_alu_op    (o_alu_op),
    .o_opcode    (o_opcode),
    .o_exception (o_exception),
    .o_ce        (o_ce)
  );

  typedef struct packed {
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [31:0]      imm;
    logic [ALU_W-1:0] alu;
    logic [OPC_W-1:0] opc;
    logic [3:0]       exc;
    logic             alu_known;
  } ref_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the registered stage
  logic        m_ce;
  ref_t        m_r;
  logic [2:0]  m_f3;
  logic [31:0] m_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Decoder behaviour written from the instruction-set rules: immediates are
  // assembled with integer arithmetic, legality as a list of rejections.
  function automatic ref_t ref_decode(input logic [31:0] in);
    ref_t r;
    int   cls;
    int   f3;
    int   f7;
    int   alu_idx;
    int   sysf;
    int   v;
    bit   bad;
    bit   ec;
    bit   eb;
    bit   mr;
    int   arith[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    int   brn[8]   = '{ALU_EQ, ALU_NE, ALU_ADD, ALU_ADD, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU};
    f3   = int'(in[14:12]);
    f7   = int'(in[31:25]);
    sysf = int'(in[31:20]);
    case (in[6:0])
      7'h33:   cls = CLS_RTYPE;
      7'h13:   cls = CLS_ITYPE;
      7'h03:   cls = CLS_LOAD;
      7'h23:   cls = CLS_STORE;
      7'h63:   cls = CLS_BRANCH;
      7'h6F:   cls = CLS_JAL;
      7'h67:   cls = CLS_JALR;
      7'h37:   cls = CLS_LUI;
      7'h17:   cls = CLS_AUIPC;
      7'h73:   cls = CLS_SYSTEM;
      7'h0F:   cls = CLS_FENCE;
      default: cls = -1;
    endcase
    bad = (in[1:0] != 2'b11) || (cls < 0);
    ec = 0; eb = 0; mr = 0;
    alu_idx = ALU_ADD;
    if (cls == CLS_RTYPE) begin
      if (f7 != 0 && f7 != 32) bad = 1;
      if (f7 == 32 && f3 != 0 && f3 != 5) bad = 1;
      alu_idx = arith[f3];
      if (in[30] && f3 == 0) alu_idx = ALU_SUB;
      if (in[30] && f3 == 5) alu_idx = ALU_SRA;
    end
    if (cls == CLS_ITYPE) begin
      alu_idx = arith[f3];
      if (f3 == 1 && f7 != 0) bad = 1;
      if (f3 == 5) begin
        if (f7 == 32) alu_idx = ALU_SRA;
        else if (f7 != 0) bad = 1;
      end
    end
    if (cls == CLS_LOAD && (f3 == 3 || f3 == 6 || f3 == 7)) bad = 1;
    if (cls == CLS_STORE && f3 > 2) bad = 1;
    if (cls == CLS_BRANCH) begin
      if (f3 == 2 || f3 == 3) bad = 1;
      alu_idx = brn[f3];
    end
    if (cls == CLS_JALR && f3 != 0) bad = 1;
    if (cls == CLS_SYSTEM) begin
      if (f3 == 4) bad = 1;
      if (f3 == 0) begin
        if (sysf == 0) ec = 1;
        else if (sysf == 1) eb = 1;
        else if (sysf == 'h302) mr = 1;
        else bad = 1;
      end
    end

    // Immediate by format
    v = 0;
    if (cls == CLS_ITYPE || cls == CLS_LOAD || cls == CLS_JALR || cls == CLS_SYSTEM ||
        cls == CLS_FENCE)
      v = int'(in[30:20]) - (in[31] ? 2048 : 0);
    else if (cls == CLS_STORE)
      v = int'(in[11:7]) + int'(in[30:25]) * 32 - (in[31] ? 2048 : 0);
    else if (cls == CLS_BRANCH)
      v = int'(in[11:8]) * 2 + int'(in[30:25]) * 32 + int'(in[7]) * 2048 - (in[31] ? 4096 : 0);
    else if (cls == CLS_LUI || cls == CLS_AUIPC)
      v = int'(in & 32'hFFFF_F000);
    else if (cls == CLS_JAL)
      v = int'(in[30:21]) * 2 + int'(in[20]) * 2048 + int'(in[19:12]) * 4096
          - (in[31] ? (1 << 20) : 0);
    r.imm = 32'(v);

    r.rs1 = (cls == CLS_LUI || cls == CLS_AUIPC || cls == CLS_JAL) ? 5'd0 : in[19:15];
    r.rs2 = (cls == CLS_RTYPE || cls == CLS_STORE || cls == CLS_BRANCH) ? in[24:20] : 5'd0;
    r.rd  = (cls == CLS_STORE || cls == CLS_BRANCH) ? 5'd0 : in[11:7];
    r.alu = ALU_W'(1) << alu_idx;
    r.opc = bad ? '0 : (OPC_W'(1) << cls);
    r.exc = {bad, ec, eb, mr};
    r.alu_known = !bad;
    return r;
  endfunction

  task automatic model_clear();
    m_ce = 1'b0;
    m_r  = '0;
    m_f3 = '0;
    m_pc = '0;
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, "_ce"},  32'(o_ce), 32'(m_ce));
    check_eq({tag, "_rd"},  32'(o_rd_addr), 32'(m_r.rd));
    check_eq({tag, "_imm"}, o_imm, m_r.imm);
    check_eq({tag, "_f3"},  32'(o_funct3), 32'(m_f3));
    check_eq({tag, "_pc"},  o_pc, m_pc);
    check_eq({tag, "_opc"}, 32'(o_opcode), 32'(m_r.opc));
    check_eq({tag, "_exc"}, 32'(o_exception), 32'(m_r.exc));
    if (m_r.alu_known) check_eq({tag, "_alu"}, 32'(o_alu_op), 32'(m_r.alu));
  endtask

  // Drive inputs, then check the combinational read addresses.
  task automatic apply(input logic [31:0] inst, input logic [31:0] pc, input logic ce,
                       input logic stall, input logic flush);
    ref_t r;
    i_inst  = inst;
    i_pc    = pc;
    i_ce    = ce;
    i_stall = stall;
    i_flush = flush;
    #1;
    r = ref_decode(inst);
    check_eq("rs1", 32'(o_rs1_addr), 32'(r.rs1));
    check_eq("rs2", 32'(o_rs2_addr), 32'(r.rs2));
  endtask

  // Advance the model and the DUT across one rising edge, then compare.
  task automatic tick(input string tag);
    if (!i_stall) begin
      if (i_ce) begin
        m_r  = ref_decode(i_inst);
        m_f3 = i_inst[14:12];
        m_pc = i_pc;
      end
      m_ce = i_flush ? 1'b0 : i_ce;
    end
    @(posedge i_clk);
    #1;
    check_regs(tag);
  endtask

  logic [6:0]  ops[11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17,
                           7'h73, 7'h0F};
  logic [11:0] sysv[3] = '{12'h000, 12'h001, 12'h302};

  initial begin
    logic [31:0] inst;
    int          k;

    i_rst = 1'b1; i_inst = '0; i_pc = '0; i_ce = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    model_clear();
    #2;
    check_regs("reset");
    #10 i_rst = 1'b0;

    // addi x1,x0,5
    apply(32'h0050_0093, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
    tick("addi");
    check_eq("addi_rd_k",  32'(o_rd_addr), 32'd1);
    check_eq("addi_imm_k", o_imm, 32'd5);
    check_eq("addi_opc_k", 32'(o_opcode), 32'd1 << CLS_ITYPE);
    check_eq("addi_alu_k", 32'(o_alu_op), 32'd1 << ALU_ADD);
    check_eq("addi_ce_k",  32'(o_ce), 32'd1);

    // sub x3,x1,x2
    apply(32'h4020_81B3, 32'h0000_0104, 1'b1, 1'b0, 1'b0);
    check_eq("sub_rs1_k", 32'(o_rs1_addr), 32'd1);
    check_eq("sub_rs2_k", 32'(o_rs2_addr), 32'd2);
    tick("sub");
    check_eq("sub_rd_k",  32'(o_rd_addr), 32'd3);
    check_eq("sub_opc_k", 32'(o_opcode), 32'd1 << CLS_RTYPE);
    check_eq("sub_alu_k", 32'(o_alu_op), 32'd1 << ALU_SUB);

    // beq x1,x2,-4
    apply(32'hFE20_8EE3, 32'h0000_0108, 1'b1, 1'b0, 1'b0);
    tick("beq");
    check_eq("beq_imm_k", o_imm, 32'hFFFF_FFFC);
    check_eq("beq_opc_k", 32'(o_opcode), 32'd1 << CLS_BRANCH);
    check_eq("beq_alu_k", 32'(o_alu_op), 32'd1 << ALU_EQ);

    apply(32'h0000_0000, 32'h0000_010C, 1'b1, 1'b0, 1'b0);
    tick("zero");
    check_eq("zero_ill_k", 32'(o_exception), 32'h8);
    check_eq("zero_opc_k", 32'(o_opcode), 32'd0);

    apply(32'h0000_0073, 32'h0000_0110, 1'b1, 1'b0, 1'b0);
    tick("ecall");
    check_eq("ecall_k", 32'(o_exception), 32'h4);

    apply(32'h3020_0073, 32'h0000_0114, 1'b1, 1'b0, 1'b0);
    tick("mret");
    check_eq("mret_k", 32'(o_exception), 32'h1);

    // Stall for three cycles with a changing instruction
    apply(32'h0050_0093, 32'h0000_0200, 1'b1, 1'b0, 1'b0);
    tick("pre_stall");
    for (int i = 0; i < 3; i++) begin
      apply($urandom, $urandom, 1'b1, 1'b1, 1'b0);
      tick("stall");
      check_eq("stall_rd_k", 32'(o_rd_addr), 32'd1);
      check_eq("stall_ce_k", 32'(o_ce), 32'd1);
    end
    apply(32'h0000_0013, 32'h0000_0204, 1'b1, 1'b1, 1'b1);
    tick("stall_flush");
    check_eq("stall_flush_ce_k", 32'(o_ce), 32'd1);
    apply(32'h0000_0013, 32'h0000_0208, 1'b1, 1'b0, 1'b1);
    tick("flush");
    check_eq("flush_ce_k", 32'(o_ce), 32'd0);

    // Reset between edges while o_ce is high
    apply(32'h0050_0093, 32'h0000_0300, 1'b1, 1'b0, 1'b0);
    tick("pre_rst");
    check_eq("pre_rst_ce_k", 32'(o_ce), 32'd1);
    #1 i_rst = 1'b1;
    #1;
    check_eq("mid_rst_ce",  32'(o_ce), 32'd0);
    check_eq("mid_rst_rd",  32'(o_rd_addr), 32'd0);
    check_eq("mid_rst_imm", o_imm, 32'd0);
    check_eq("mid_rst_f3",  32'(o_funct3), 32'd0);
    check_eq("mid_rst_pc",  o_pc, 32'd0);
    check_eq("mid_rst_alu", 32'(o_alu_op), 32'd0);
    check_eq("mid_rst_opc", 32'(o_opcode), 32'd0);
    check_eq("mid_rst_exc", 32'(o_exception), 32'd0);
    model_clear();
    #1 i_rst = 1'b0;
    apply(32'h4020_81B3, 32'h0000_0304, 1'b1, 1'b0, 1'b0);
    tick("post_rst");
    check_eq("post_rst_rd_k", 32'(o_rd_addr), 32'd3);
    check_eq("post_rst_ce_k", 32'(o_ce), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      inst = $urandom;
      k = $urandom_range(0, 11);
      if (k < 11) inst[6:0] = ops[k];
      if ($urandom_range(0, 1) == 1) inst[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if (k == 9 && $urandom_range(0, 1) == 1) begin
        inst[14:12] = 3'b000;
        inst[31:20] = sysv[$urandom_range(0, 2)];
      end
      apply(inst, $urandom, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2,
            $urandom_range(0, 9) < 1);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
